// File: rtl/prim_memif_pkg.sv
// Shared types for the Prim memory-access unit: FSM states, byte-lane
// constants and the access-form classification used at request accept.
package prim_memif_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CYC0 = 2'd1,
      ST_CYC1 = 2'd2,
      ST_FIN  = 2'd3
   } state_t;

   localparam logic [1:0] BS_NONE = 2'b00;
   localparam logic [1:0] BS_LO   = 2'b01;
   localparam logic [1:0] BS_WORD = 2'b11;

   typedef enum logic [1:0] {
      AF_BYTE   = 2'd0,
      AF_WORD   = 2'd1,
      AF_SPLIT  = 2'd2,
      AF_REJECT = 2'd3
   } form_t;

   // An odd 16-bit access either becomes two byte cycles or is refused.
   function automatic form_t classify(input logic size16, input logic a0,
                                      input logic split_en);
      form_t f;
      if (!size16)       f = AF_BYTE;
      else if (!a0)      f = AF_WORD;
      else if (split_en) f = AF_SPLIT;
      else               f = AF_REJECT;
      return f;
   endfunction

endpackage

// File: rtl/prim_memif_if.sv
// Core-side request and bus-side strobe/ack signals of prim_memif.
// slave  : the view taken by prim_memif itself.
// master : the view of its environment (execute stage plus external bus).
interface prim_memif_if #(parameter int ADDR_WIDTH = 16);
   logic                  i_req;
   logic                  i_we;
   logic                  i_size16;
   logic [ADDR_WIDTH-1:0] i_addr;
   logic [15:0]           i_wdat;
   logic                  o_busy;
   logic                  o_done;
   logic [15:0]           o_rdat;
   logic                  o_err;
   logic [ADDR_WIDTH-1:0] o_addr;
   logic [15:0]           o_dat;
   logic [15:0]           i_dat;
   logic [1:0]            o_bs;
   logic                  o_we;
   logic                  o_stb;
   logic                  i_ack;

   modport slave (
      input  i_req, i_we, i_size16, i_addr, i_wdat, i_dat, i_ack,
      output o_busy, o_done, o_rdat, o_err, o_addr, o_dat, o_bs, o_we, o_stb
   );

   modport master (
      output i_req, i_we, i_size16, i_addr, i_wdat, i_dat, i_ack,
      input  o_busy, o_done, o_rdat, o_err, o_addr, o_dat, o_bs, o_we, o_stb
   );
endinterface

// File: rtl/prim_memif_timer.sv
// Bus-cycle wait counter. Cleared when a bus cycle begins, counts strobe
// cycles without acknowledge, flags expiry on the last allowed wait cycle.
// Only instantiated when PRIM_MEMIF_TIMEOUT_EN is defined.
module prim_memif_timer #(
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clr,
   input  logic i_run,
   output logic o_expired
);
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q;

   assign o_expired = i_run && (cnt_q == LAST);

   // Wait counter; holds once expired until the next clear.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)                    cnt_q <= '0;
      else if (i_clr)                 cnt_q <= '0;
      else if (i_run && !o_expired)   cnt_q <= cnt_q + CW'(1);
   end
endmodule

// File: rtl/prim_memif.sv
// Prim core memory-access unit: turns one core request into one or two
// strobe/ack bus cycles. Odd 16-bit accesses are split into two byte cycles
// (or refused when SPLIT_UNALIGNED=0). Define PRIM_MEMIF_TIMEOUT_EN to add a
// per-bus-cycle watchdog that aborts after TIMEOUT_CYCLES unacknowledged cycles.
module prim_memif
   import prim_memif_pkg::*;
#(
   parameter int ADDR_WIDTH      = 16,
   parameter bit SPLIT_UNALIGNED = 1'b1,
   parameter int TIMEOUT_CYCLES  = 15
) (
   input  logic         i_clk,
   input  logic         i_reset,
   prim_memif_if.slave  bus
);
   localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   state_t                state_q;
   form_t                 form_q;
   form_t                 form_d;
   logic [7:0]            hi_q;
   logic [15:0]           rbuf_q;
   logic                  err_q;
   logic                  stb_q, we_q, busy_q, done_q, oerr_q;
   logic [1:0]            bs_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [15:0]           dat_q, rdat_q;
   logic                  tmo;

   assign form_d = classify(bus.i_size16, bus.i_addr[0], SPLIT_UNALIGNED);

`ifdef PRIM_MEMIF_TIMEOUT_EN
   logic tmr_clr, tmr_run;

   // Restart the watchdog whenever a CYC0 or CYC1 bus cycle is entered.
   always_comb begin
      tmr_clr = ((state_q == ST_IDLE) && bus.i_req && (form_d != AF_REJECT))
             || ((state_q == ST_CYC0) && stb_q && bus.i_ack && (form_q == AF_SPLIT));
      tmr_run = stb_q && !bus.i_ack;
   end

   prim_memif_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_clr     (tmr_clr),
      .i_run     (tmr_run),
      .o_expired (tmo)
   );
`else
   assign tmo = 1'b0;
`endif

   // Transaction FSM; every bus and core output is a register set here.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= ST_IDLE;
         form_q  <= AF_BYTE;
         hi_q    <= '0;
         rbuf_q  <= '0;
         err_q   <= 1'b0;
         stb_q   <= 1'b0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         oerr_q  <= 1'b0;
         bs_q    <= BS_NONE;
         addr_q  <= '0;
         dat_q   <= '0;
         rdat_q  <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               oerr_q <= 1'b0;
               if (bus.i_req) begin
                  busy_q <= 1'b1;
                  form_q <= form_d;
                  we_q   <= bus.i_we;
                  addr_q <= bus.i_addr;
                  hi_q   <= bus.i_wdat[15:8];
                  rbuf_q <= '0;
                  err_q  <= 1'b0;
                  bs_q   <= (form_d == AF_WORD) ? BS_WORD : BS_LO;
                  dat_q  <= (form_d == AF_WORD) ? bus.i_wdat : {8'h00, bus.i_wdat[7:0]};
                  if (form_d == AF_REJECT) begin
                     err_q   <= 1'b1;
                     state_q <= ST_FIN;
                  end else begin
                     stb_q   <= 1'b1;
                     state_q <= ST_CYC0;
                  end
               end
            end
            ST_CYC0: begin
               if (stb_q && bus.i_ack) begin
                  stb_q  <= 1'b0;
                  rbuf_q <= (form_q == AF_WORD) ? bus.i_dat : {8'h00, bus.i_dat[7:0]};
                  if (form_q == AF_SPLIT) begin
                     // Second byte goes to the next address, wrapping at the top.
                     addr_q  <= addr_q + ONE;
                     dat_q   <= {8'h00, hi_q};
                     state_q <= ST_CYC1;
                  end else begin
                     state_q <= ST_FIN;
                  end
               end else if (stb_q && tmo) begin
                  stb_q   <= 1'b0;
                  err_q   <= 1'b1;
                  state_q <= ST_FIN;
               end
            end
            ST_CYC1: begin
               // First CYC1 cycle is the strobe-low gap between the two bytes.
               if (!stb_q) begin
                  stb_q <= 1'b1;
               end else if (bus.i_ack) begin
                  stb_q         <= 1'b0;
                  rbuf_q[15:8]  <= bus.i_dat[7:0];
                  state_q       <= ST_FIN;
               end else if (tmo) begin
                  stb_q   <= 1'b0;
                  err_q   <= 1'b1;
                  state_q <= ST_FIN;
               end
            end
            ST_FIN: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               oerr_q  <= err_q;
               state_q <= ST_IDLE;
               if (err_q)      rdat_q <= '0;
               else if (!we_q) rdat_q <= rbuf_q;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.o_stb  = stb_q;
   assign bus.o_we   = we_q;
   assign bus.o_busy = busy_q;
   assign bus.o_done = done_q;
   assign bus.o_err  = oerr_q;
   assign bus.o_bs   = bs_q;
   assign bus.o_addr = addr_q;
   assign bus.o_dat  = dat_q;
   assign bus.o_rdat = rdat_q;
endmodule

// File: tb/tb_prim_memif.sv
// Self-checking bench for prim_memif: directed cases, randomized
// transactions against a byte-lane reference model, reset abort, and the
// rejected-unaligned build. Timeout case runs when PRIM_MEMIF_TIMEOUT_EN is set.
module tb_prim_memif;
   localparam int TMO = 4;

   logic i_clk = 1'b0;
   logic i_reset;
   int   errors = 0;
   int   checks = 0;

   always #5 i_clk = ~i_clk;

   prim_memif_if #(.ADDR_WIDTH(16)) bi ();
   prim_memif_if #(.ADDR_WIDTH(16)) bz ();

   prim_memif #(.ADDR_WIDTH(16), .SPLIT_UNALIGNED(1'b1), .TIMEOUT_CYCLES(TMO)) u_dut (
      .i_clk(i_clk), .i_reset(i_reset), .bus(bi.slave));

   prim_memif #(.ADDR_WIDTH(16), .SPLIT_UNALIGNED(1'b0), .TIMEOUT_CYCLES(TMO)) u_dut_nosplit (
      .i_clk(i_clk), .i_reset(i_reset), .bus(bz.slave));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // One core transaction on bi with a responding bus. d0/d1 = ack wait per
   // bus cycle; d0 < 0 means never acknowledge. r0/r1 = bus read data.
   task automatic txn(input string tag, input logic we, input logic sz,
                      input logic [15:0] addr, input logic [15:0] wdat,
                      input int d0, input int d1,
                      input logic [15:0] r0, input logic [15:0] r1);
      logic [15:0] ea [2];
      logic [1:0]  eb [2];
      logic [15:0] ed [2];
      logic [15:0] erd;
      int          ncyc, elat, seen, wt, stb_cnt, dl;
      logic        eerr, prev_stb, done_seen, tmo;
      tmo   = (d0 < 0);
      ea[0] = addr;          eb[0] = 2'b01; ed[0] = {8'h00, wdat[7:0]};
      ea[1] = addr + 16'd1;  eb[1] = 2'b01; ed[1] = {8'h00, wdat[15:8]};
      erd   = {8'h00, r0[7:0]};
      ncyc  = 1;
      if (sz && !addr[0]) begin
         eb[0] = 2'b11; ed[0] = wdat; erd = r0;
      end else if (sz) begin
         ncyc = 2; erd = {r1[7:0], r0[7:0]};
      end
      elat = (ncyc == 1) ? 3 + d0 : 5 + d0 + d1;
      eerr = 1'b0;
      if (tmo) begin
         eerr = 1'b1; erd = '0; ncyc = 1; elat = 2 + TMO;
      end
      bi.i_req = 1'b1; bi.i_we = we; bi.i_size16 = sz; bi.i_addr = addr; bi.i_wdat = wdat;
      seen = 0; wt = 0; stb_cnt = 0; prev_stb = 1'b0; done_seen = 1'b0;
      for (int n = 1; n <= 200 && !done_seen; n++) begin
         @(negedge i_clk);
         bi.i_req = 1'b0; bi.i_ack = 1'b0; bi.i_dat = 16'($urandom);
         if (n == 1) chk({tag, " busy"}, bi.o_busy, 1);
         if (bi.o_stb) begin
            if (!prev_stb) begin
               if (seen < ncyc) begin
                  chk({tag, " addr"}, bi.o_addr, ea[seen]);
                  chk({tag, " bs"},   bi.o_bs,   eb[seen]);
                  chk({tag, " we"},   bi.o_we,   we);
                  if (we) chk({tag, " wdat"}, bi.o_dat, ed[seen]);
               end else begin
                  chk({tag, " extra cycle"}, seen, ncyc);
               end
               seen++; wt = 0;
            end
            stb_cnt++;
            dl = (seen == 1) ? d0 : d1;
            if (!tmo && wt == dl) begin
               bi.i_ack = 1'b1;
               bi.i_dat = (seen == 1) ? r0 : r1;
            end
            wt++;
         end
         prev_stb = bi.o_stb;
         if (bi.o_done) begin
            done_seen = 1'b1;
            chk({tag, " latency"}, n, elat);
            chk({tag, " err"}, bi.o_err, eerr);
            chk({tag, " busy@done"}, bi.o_busy, 0);
            chk({tag, " cycles"}, seen, ncyc);
            if (!we || eerr) chk({tag, " rdat"}, bi.o_rdat, erd);
            if (tmo) chk({tag, " stb wait"}, stb_cnt, TMO);
         end
      end
      chk({tag, " done"}, done_seen, 1);
   endtask

   initial begin
      logic        rwe, rsz;
      logic [15:0] raddr, rwdat, rr0, rr1;
      int          rises, zdone_n;
      logic        prev, zstb;

      i_reset = 1'b1;
      bi.i_req = 0; bi.i_we = 0; bi.i_size16 = 0; bi.i_addr = 0; bi.i_wdat = 0;
      bi.i_dat = 0; bi.i_ack = 0;
      bz.i_req = 0; bz.i_we = 0; bz.i_size16 = 0; bz.i_addr = 0; bz.i_wdat = 0;
      bz.i_dat = 0; bz.i_ack = 0;
      repeat (2) @(negedge i_clk);
      chk("rst stb",  bi.o_stb,  0);
      chk("rst we",   bi.o_we,   0);
      chk("rst busy", bi.o_busy, 0);
      chk("rst done", bi.o_done, 0);
      chk("rst err",  bi.o_err,  0);
      chk("rst bs",   bi.o_bs,   0);
      chk("rst addr", bi.o_addr, 0);
      chk("rst dat",  bi.o_dat,  0);
      chk("rst rdat", bi.o_rdat, 0);
      chk("rst z stb", bz.o_stb, 0);
      i_reset = 1'b0;

      // Directed cases
      txn("rd16 aligned", 1'b0, 1'b1, 16'h0010, 16'h0000, 2, 0, 16'hBEEF, 16'h0000);
      txn("wr16 odd",     1'b1, 1'b1, 16'h0021, 16'h1234, 0, 0, 16'h0000, 16'h0000);
      txn("rd16 wrap",    1'b0, 1'b1, 16'hFFFF, 16'h0000, 0, 1, 16'h55AB, 16'h77CD);
      txn("rd8",          1'b0, 1'b0, 16'h0033, 16'h0000, 1, 0, 16'h9A5C, 16'h0000);
      txn("wr8",          1'b1, 1'b0, 16'h0040, 16'hFF7E, 0, 0, 16'h0000, 16'h0000);
      txn("wr16 aligned", 1'b1, 1'b1, 16'h0100, 16'hC3A5, 3, 0, 16'h0000, 16'h0000);

      // Randomized transactions, back to back
      for (int k = 0; k < 40; k++) begin
         rwe   = 1'($urandom_range(0, 1));
         rsz   = 1'($urandom_range(0, 1));
         raddr = 16'($urandom);
         rwdat = 16'($urandom);
         rr0   = 16'($urandom);
         rr1   = 16'($urandom);
         txn("rnd", rwe, rsz, raddr, rwdat, int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), rr0, rr1);
      end

      // Reset during the second byte cycle of a split write
      bi.i_req = 1'b1; bi.i_we = 1'b1; bi.i_size16 = 1'b1; bi.i_addr = 16'h0041;
      bi.i_wdat = 16'h5A5A;
      rises = 0; prev = 1'b0;
      for (int n = 1; n <= 20 && rises < 2; n++) begin
         @(negedge i_clk);
         bi.i_req = 1'b0; bi.i_ack = 1'b0;
         if (bi.o_stb && !prev) begin
            rises++;
            if (rises == 1) bi.i_ack = 1'b1;
         end
         prev = bi.o_stb;
      end
      chk("rst cyc1 reached", rises, 2);
      chk("rst cyc1 addr", bi.o_addr, 16'h0042);
      i_reset = 1'b1;
      #1;
      chk("rst mid stb",  bi.o_stb,  0);
      chk("rst mid busy", bi.o_busy, 0);
      chk("rst mid done", bi.o_done, 0);
      @(negedge i_clk);
      i_reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge i_clk);
         chk("rst no done", bi.o_done, 0);
      end
      txn("after rst", 1'b0, 1'b1, 16'h0042, 16'h0000, 0, 0, 16'h1357, 16'h0000);

      // Unaligned 16-bit read refused when splitting is disabled
      bz.i_req = 1'b1; bz.i_we = 1'b0; bz.i_size16 = 1'b1; bz.i_addr = 16'h0003;
      zstb = 1'b0; zdone_n = 0;
      for (int n = 1; n <= 10 && zdone_n == 0; n++) begin
         @(negedge i_clk);
         bz.i_req = 1'b0;
         if (bz.o_stb) zstb = 1'b1;
         if (bz.o_done) begin
            zdone_n = n;
            chk("rej err",  bz.o_err,  1);
            chk("rej rdat", bz.o_rdat, 0);
            chk("rej busy", bz.o_busy, 0);
         end
      end
      chk("rej latency", zdone_n, 2);
      chk("rej no stb", zstb, 0);

`ifdef PRIM_MEMIF_TIMEOUT_EN
      txn("timeout", 1'b0, 1'b1, 16'h0200, 16'h0000, -1, 0, 16'h0000, 16'h0000);
      txn("post tmo", 1'b0, 1'b0, 16'h0201, 16'h0000, 0, 0, 16'h00E1, 16'h0000);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
